// File: rtl/reward_gen_pkg.sv
// rtl/reward_gen_pkg.sv - shared types, default bases and address helper for reward_gen
//
// Purpose: FSM state encoding, default memory-map bases and the word-index
//          to byte-address helper shared by reward_gen and its sub-module.
// Ports:   none (package).

package reward_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WR_NODE,
    RD_REQ,
    RD_WAIT,
    WR_CLUS,
    WR_REW,
    DONE
  } state_e;

  localparam logic [15:0] DEF_BASE_NODE = 16'h0148;
  localparam logic [15:0] DEF_BASE_Q    = 16'h01C8;
  localparam logic [15:0] DEF_BASE_PKT  = 16'h0048;

  // Word index to byte address. Callers truncate the result to their address
  // width, which gives the required modulo wrap and drops the index MSB.
  function automatic logic [31:0] addr_calc(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 1);
  endfunction

endpackage

// File: rtl/reward_gen_min_tracker.sv
// rtl/reward_gen_min_tracker.sv - running unsigned minimum with its index
//
// Purpose: tracks the smallest sampled value and the index it came from.
//          A tie keeps the earlier (lower-index) entry.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         forget the current minimum
//   sample_i        offer value_i/index_i this cycle
//   value_i         candidate value
//   index_i         candidate index
//   min_value_o     current minimum (registered)
//   min_index_o     index of current minimum (registered)
//   take_o          candidate this cycle becomes the new minimum

module reward_min_tracker #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 sample_i,
  input  logic [WIDTH-1:0]     value_i,
  input  logic [IDX_WIDTH-1:0] index_i,
  output logic [WIDTH-1:0]     min_value_o,
  output logic [IDX_WIDTH-1:0] min_index_o,
  output logic                 take_o
);

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     min_q, min_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;

  // Strict less-than keeps the first of equal values.
  assign take_o = sample_i && (!valid_q || (value_i < min_q));

  always_comb begin
    valid_d = valid_q;
    min_d   = min_q;
    idx_d   = idx_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (take_o) begin
      valid_d = 1'b1;
      min_d   = value_i;
      idx_d   = index_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      min_q   <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
    end
  end

  assign min_value_o = min_q;
  assign min_index_o = idx_q;

endmodule

// File: rtl/reward_gen.sv
// rtl/reward_gen.sv - cluster-node reward update engine
//
// Purpose: on start, writes MY_NODE_ID into the node table, fetches a reward
//          from the Q table (direct index or minimum scan), then writes the
//          cluster ID and reward into the packet buffer slot given by action.
// Ports:
//   clock, nrst          clock, asynchronous active-low reset
//   en                   enable; low aborts any operation
//   start                begin operation (honoured in ARMED)
//   mode                 0 = Q[besthop], 1 = min over Q[0..NUM_NEIGHBORS-1]
//   MY_NODE_ID           node identifier
//   MY_CLUSTER_ID        cluster identifier
//   action               packet slot index
//   besthop              Q index used in mode 0
//   data_in              memory read data
//   address, data_out    memory byte address / write data
//   wr_en, rd_en         one-cycle write / read strobes
//   busy                 operation in progress
//   best_idx             index of the reward source
//   done                 completion flag

module reward_gen
  import reward_gen_pkg::*;
#(
  parameter int                    WORD_WIDTH    = 16,
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    RD_LATENCY    = 1,
  parameter int                    NUM_NEIGHBORS = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_NODE     = DEF_BASE_NODE,
  parameter logic [ADDR_WIDTH-1:0] BASE_Q        = DEF_BASE_Q,
  parameter logic [ADDR_WIDTH-1:0] BASE_PKT      = DEF_BASE_PKT
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
  input  logic [WORD_WIDTH-1:0] action,
  input  logic [WORD_WIDTH-1:0] besthop,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] best_idx,
  output logic                  done
);

  localparam logic [2:0] LAST_WAIT = 3'(RD_LATENCY - 1);
  localparam logic [7:0] LAST_NBR  = 8'(NUM_NEIGHBORS - 1);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [WORD_WIDTH-1:0] cluster_q, cluster_d;
  logic [WORD_WIDTH-1:0] action_q, action_d;
  logic [WORD_WIDTH-1:0] besthop_q, besthop_d;
  logic [WORD_WIDTH-1:0] reward_q, reward_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            wait_q, wait_d;

  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic [WORD_WIDTH-1:0] best_idx_q, best_idx_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  capture;
  logic                  sample;
  logic                  take;
  logic                  last_entry;
  logic [WORD_WIDTH-1:0] min_value;
  logic [WORD_WIDTH-1:0] min_index;

  assign accept     = (state_q == ARMED) && en && start;
  assign capture    = (state_q == RD_WAIT) && en && (wait_q == LAST_WAIT);
  assign sample     = capture && mode_q;
  assign last_entry = !mode_q || (cnt_q == LAST_NBR);

  reward_min_tracker #(
    .WIDTH     (WORD_WIDTH),
    .IDX_WIDTH (WORD_WIDTH)
  ) u_min (
    .clk_i       (clock),
    .rst_ni      (nrst),
    .clear_i     (accept),
    .sample_i    (sample),
    .value_i     (data_in),
    .index_i     (WORD_WIDTH'(cnt_q)),
    .min_value_o (min_value),
    .min_index_o (min_index),
    .take_o      (take)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cluster_d  = cluster_q;
    action_d   = action_q;
    besthop_d  = besthop_q;
    reward_d   = reward_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    best_idx_d = best_idx_q;
    done_d     = done_q;

    // Transitions. Dropping en abort-returns to IDLE from anywhere.
    if (!en && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_d = ARMED;
            done_d  = 1'b0;
          end
        end
        ARMED: begin
          if (accept) begin
            state_d   = WR_NODE;
            mode_d    = mode;
            cluster_d = MY_CLUSTER_ID;
            action_d  = action;
            besthop_d = besthop;
            cnt_d     = '0;
          end
        end
        WR_NODE: state_d = RD_REQ;
        RD_REQ: begin
          state_d = RD_WAIT;
          wait_d  = '0;
        end
        RD_WAIT: begin
          if (capture) begin
            if (last_entry) begin
              state_d = WR_CLUS;
            end else begin
              cnt_d   = cnt_q + 8'd1;
              state_d = RD_REQ;
            end
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
        WR_CLUS: state_d = WR_REW;
        WR_REW:  state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (capture && !mode_q) begin
      reward_d   = data_in;
      best_idx_d = besthop_q;
    end
    if (take) begin
      best_idx_d = WORD_WIDTH'(cnt_q);
    end

    // Outputs are registered: decode them from the state being entered.
    unique case (state_d)
      WR_NODE: begin
        address_d  = ADDR_WIDTH'(addr_calc(32'(BASE_NODE), 32'(MY_CLUSTER_ID)));
        data_out_d = MY_NODE_ID;
        wr_en_d    = 1'b1;
      end
      RD_REQ: begin
        address_d = ADDR_WIDTH'(addr_calc(32'(BASE_Q),
                                mode_q ? 32'(cnt_d) : 32'(besthop_q)));
        rd_en_d   = 1'b1;
      end
      WR_CLUS: begin
        address_d  = ADDR_WIDTH'(addr_calc(32'(BASE_PKT), 32'(action_q)));
        data_out_d = cluster_q;
        wr_en_d    = 1'b1;
      end
      WR_REW: begin
        address_d  = ADDR_WIDTH'(addr_calc(32'(BASE_PKT), 32'(action_q)) + 32'd2);
        data_out_d = mode_q ? min_value : reward_q;
        wr_en_d    = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != IDLE) && (state_d != ARMED);
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      cluster_q  <= '0;
      action_q   <= '0;
      besthop_q  <= '0;
      reward_q   <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      address_q  <= '0;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      best_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cluster_q  <= cluster_d;
      action_q   <= action_d;
      besthop_q  <= besthop_d;
      reward_q   <= reward_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      best_idx_q <= best_idx_d;
      done_q     <= done_d;
    end
  end

  assign address  = address_q;
  assign data_out = data_out_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign busy     = busy_q;
  assign best_idx = best_idx_q;
  assign done     = done_q;

  // min_index mirrors best_idx in mode 1; kept on the tracker for reuse.
  logic unused_min_index;
  assign unused_min_index = ^min_index;

endmodule

// File: tb/tb_reward_gen.sv
// tb/tb_reward_gen.sv - directed self-checking bench for reward_gen

module tb_reward_gen;

  logic        clock = 1'b0;
  logic        nrst, en, start, mode;
  logic [15:0] node_id, clus_id, action, besthop;
  logic        log_clr;
  logic [15:0] qmem [8];
  int          done_at [2];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  function automatic logic [15:0] q_lookup(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h01C8;
    if (a >= 16'h01C8 && off < 16'd16) return qmem[off[3:1]];
    return 16'hBEEF;
  endfunction

  // Instance 0: RD_LATENCY=1, NUM_NEIGHBORS=4. Instance 1: RD_LATENCY=3, 8.
  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int NN  = (g == 0) ? 4 : 8;
    logic [15:0] address, data_out, data_in, best_idx;
    logic        wr_en, rd_en, busy, done;
    int          cnt = 0;
    int          wn = 0;
    int          rn = 0;
    bit          both = 1'b0;
    logic [15:0] pend_data;
    logic [31:0] wlog [8];
    logic [15:0] rlog [8];

    reward_gen #(.RD_LATENCY(LAT), .NUM_NEIGHBORS(NN)) u_dut (
      .clock(clock), .nrst(nrst), .en(en), .start(start), .mode(mode),
      .MY_NODE_ID(node_id), .MY_CLUSTER_ID(clus_id), .action(action),
      .besthop(besthop), .data_in(data_in), .address(address),
      .data_out(data_out), .wr_en(wr_en), .rd_en(rd_en), .busy(busy),
      .best_idx(best_idx), .done(done)
    );

    // Memory: data is valid only in the single cycle ending on the
    // LAT-th edge after the read strobe was sampled.
    always @(negedge clock) begin
      if (rd_en) begin
        pend_data <= q_lookup(address);
        cnt       <= LAT + 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
      end
      if (log_clr) begin
        wn   <= 0;
        rn   <= 0;
        both <= 1'b0;
      end else begin
        if (wr_en && wn < 8) begin
          wlog[wn] <= {address, data_out};
          wn       <= wn + 1;
        end
        if (rd_en && rn < 8) begin
          rlog[rn] <= address;
          rn       <= rn + 1;
        end
        if (wr_en && rd_en) both <= 1'b1;
      end
    end
    assign data_in = (cnt == 1) ? pend_data : 16'hDEAD;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
  endtask

  // Pulses start in ARMED and scrambles inputs after the accept edge; records
  // the edge (accept edge = 0) at which each done first rises.
  task automatic run_op();
    done_at[0] = -1;
    done_at[1] = -1;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin
        start   = 1'b0;
        mode    = ~mode;
        action  = action ^ 16'h00F0;
        clus_id = clus_id ^ 16'h0008;
        node_id = node_id ^ 16'hFF00;
        besthop = besthop ^ 16'h0001;
      end
      if (g_i[0].done && done_at[0] < 0) done_at[0] = n - 1;
      if (g_i[1].done && done_at[1] < 0) done_at[1] = n - 1;
    end
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; start = 1'b0; mode = 1'b0; log_clr = 1'b0;
    node_id = '0; clus_id = '0; action = '0; besthop = '0;
    qmem = '{16'd9, 16'd4, 16'h0040, 16'd4, 16'd100, 16'd100, 16'd100, 16'd100};
    repeat (2) tick();

    // Reset state
    chk("rst_address", g_i[0].address, 0);
    chk("rst_data_out", g_i[0].data_out, 0);
    chk("rst_wr_en", g_i[0].wr_en, 0);
    chk("rst_rd_en", g_i[0].rd_en, 0);
    chk("rst_busy", g_i[0].busy, 0);
    chk("rst_best_idx", g_i[0].best_idx, 0);
    chk("rst_done", g_i[0].done, 0);
    nrst = 1'b1;
    tick();

    // start while IDLE with en low is ignored
    start = 1'b1;
    repeat (3) tick();
    chk("start_no_en_busy", g_i[0].busy, 0);
    start = 1'b0;

    // Mode 0, both latencies
    mode = 1'b0; node_id = 16'h00A5; clus_id = 16'd3; besthop = 16'd2; action = 16'd1;
    en = 1'b1;
    clr_logs();
    run_op();
    chk("m0_done_edge_l1", done_at[0], 5);
    chk("m0_done_edge_l3", done_at[1], 7);
    chk("m0_nwrites", g_i[0].wn, 3);
    chk("m0_wr_node", g_i[0].wlog[0], 32'h014E_00A5);
    chk("m0_wr_clus", g_i[0].wlog[1], 32'h004A_0003);
    chk("m0_wr_rew", g_i[0].wlog[2], 32'h004C_0040);
    chk("m0_nreads", g_i[0].rn, 1);
    chk("m0_rd_addr", g_i[0].rlog[0], 16'h01CC);
    chk("m0_best_idx", g_i[0].best_idx, 2);
    chk("m0_l3_nreads", g_i[1].rn, 1);
    chk("m0_l3_wr_rew", g_i[1].wlog[2], 32'h004C_0040);
    chk("m0_done_cleared", g_i[0].done, 0);

    // Mode 1 scan: min 4 at indices 1 and 3, lower index wins
    qmem = '{16'd9, 16'd4, 16'd7, 16'd4, 16'd100, 16'd100, 16'd100, 16'd100};
    mode = 1'b1; node_id = 16'h00A5; clus_id = 16'd3; besthop = 16'd6; action = 16'd1;
    clr_logs();
    run_op();
    chk("m1_done_edge", done_at[0], 11);
    chk("m1_nreads", g_i[0].rn, 4);
    chk("m1_rd0", g_i[0].rlog[0], 16'h01C8);
    chk("m1_rd1", g_i[0].rlog[1], 16'h01CA);
    chk("m1_rd2", g_i[0].rlog[2], 16'h01CC);
    chk("m1_rd3", g_i[0].rlog[3], 16'h01CE);
    chk("m1_wr_rew", g_i[0].wlog[2], 32'h004C_0004);
    chk("m1_best_idx", g_i[0].best_idx, 1);
    chk("m1_l3_done_edge", done_at[1], 35);
    chk("m1_l3_best_idx", g_i[1].best_idx, 1);
    chk("m1_l3_nreads", g_i[1].rn, 8);

    // Address wrap in the packet buffer
    mode = 1'b0; node_id = 16'h0011; clus_id = 16'd3; besthop = 16'd2; action = 16'h7FFF;
    clr_logs();
    run_op();
    chk("wrap_clus", g_i[0].wlog[1], 32'h0046_0003);
    chk("wrap_rew", g_i[0].wlog[2], 32'h0048_0007);
    chk("no_overlap_0", g_i[0].both, 0);
    chk("no_overlap_1", g_i[1].both, 0);

    // Abort during RD_WAIT
    mode = 1'b0; node_id = 16'h00A5; clus_id = 16'd3; besthop = 16'd2; action = 16'd1;
    clr_logs();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("abort_busy_before", g_i[0].busy, 1);
    en = 1'b0;
    tick();
    chk("abort_busy", g_i[0].busy, 0);
    chk("abort_rd_en", g_i[0].rd_en, 0);
    chk("abort_wr_en", g_i[0].wr_en, 0);
    repeat (6) tick();
    chk("abort_nwrites", g_i[0].wn, 1);
    chk("abort_nwrites_l3", g_i[1].wn, 1);
    chk("abort_done", g_i[0].done, 0);
    en = 1'b1;
    tick();
    clr_logs();
    run_op();
    chk("abort_recover_done", done_at[0], 5);
    chk("abort_recover_nwr", g_i[0].wn, 3);

    // Async reset pulse during WR_NODE
    mode = 1'b0; clus_id = 16'd3; node_id = 16'h00A5; besthop = 16'd2; action = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wrnode_wr_en", g_i[0].wr_en, 1);
    #1 nrst = 1'b0;
    #1;
    chk("arst_address", g_i[0].address, 0);
    chk("arst_data_out", g_i[0].data_out, 0);
    chk("arst_wr_en", g_i[0].wr_en, 0);
    chk("arst_busy", g_i[0].busy, 0);
    chk("arst_best_idx", g_i[0].best_idx, 0);
    chk("arst_wr_en_l3", g_i[1].wr_en, 0);
    en = 1'b0;
    tick();
    nrst = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", g_i[0].busy, 0);
    chk("post_rst_wr_en", g_i[0].wr_en, 0);
    chk("post_rst_done", g_i[0].done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reward_gen.md
Name: reward_gen

Overview:
- Parametrised successor of the cluster-node reward update engine in the routing/Q-learning datapath.
- On start, it does three things in order: writes MY_NODE_ID into the node table, fetches a reward value from the Q table, then writes the cluster ID and the reward into the packet buffer slot chosen by action.
- Adds over the previous generation: explicit read/write strobes, configurable memory read latency, programmable base addresses, a neighbour-scan (minimum search) mode, abort on en deassert, and a busy flag.

Parameters:
- WORD_WIDTH, 16, data word width.
- ADDR_WIDTH, 16, byte address width.
- RD_LATENCY, 1, cycles from rd_en to valid data_in; legal range 1..7.
- NUM_NEIGHBORS, 8, entries scanned in mode 1; legal range 1..255.
- BASE_NODE, 16'h148, byte base of the node table.
- BASE_Q, 16'h1C8, byte base of the Q table.
- BASE_PKT, 16'h48, byte base of the packet buffer.

Ports:
- clock  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  block enable; low aborts any operation.
- start  in  1  begin operation; honoured only in ARMED.
- mode  in  1  0 = copy Q[besthop]; 1 = minimum over Q[0..NUM_NEIGHBORS-1].
- MY_NODE_ID  in  WORD_WIDTH  node identifier.
- MY_CLUSTER_ID  in  WORD_WIDTH  cluster identifier.
- action  in  WORD_WIDTH  packet slot index.
- besthop  in  WORD_WIDTH  Q-table index used in mode 0.
- data_in  in  WORD_WIDTH  memory read data.
- address  out  ADDR_WIDTH  memory byte address.
- data_out  out  WORD_WIDTH  memory write data.
- wr_en  out  1  write strobe, one cycle per write.
- rd_en  out  1  read strobe, one cycle per read.
- busy  out  1  high in any state other than IDLE and ARMED.
- best_idx  out  WORD_WIDTH  index of the reward source: besthop in mode 0, argmin in mode 1.
- done  out  1  completion flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting nrst forces state IDLE and drives address, data_out, wr_en, rd_en, busy, best_idx and done to 0 immediately, including mid-operation.
- All outputs are registered.
- Address rule: addr(base, idx) = base + {idx[ADDR_WIDTH-2:0], 1'b0}, computed modulo 2^ADDR_WIDTH (wrap, no saturation).
- Input capture: on the start-accepting edge, latch mode, MY_NODE_ID, MY_CLUSTER_ID, action and besthop. Later input changes have no effect on the operation in progress.

State machine:
- IDLE: if en, go to ARMED and clear done.
- ARMED: if start, latch inputs and go to WR_NODE. Otherwise stay.
- WR_NODE: address = addr(BASE_NODE, cluster), data_out = node_id, wr_en = 1, for one cycle.
- RD_REQ: address = addr(BASE_Q, idx), rd_en = 1, for one cycle.
  - Mode 0: idx = besthop.
  - Mode 1: idx = scan counter, starting at 0.
- RD_WAIT: hold for RD_LATENCY cycles, with rd_en = 0 and address held. Capture data_in on the final wait edge.
  - Mode 0: reward = data_in.
  - Mode 1: if this is the first entry, or data_in < current min (unsigned), then min = data_in and best_idx = idx. Ties keep the lower index.
  - Mode 1 with counter < NUM_NEIGHBORS-1: increment the counter and return to RD_REQ. Otherwise go to WR_CLUS.
- WR_CLUS: address = addr(BASE_PKT, action), data_out = cluster, wr_en = 1.
- WR_REW: address = addr(BASE_PKT, action) + 2, data_out = reward, wr_en = 1.
- DONE: set done = 1 and return to IDLE. done holds until the next IDLE-to-ARMED transition.

Latency and strobes:
- done rises 3 + R*(1+RD_LATENCY) edges after the start edge, where R = 1 in mode 0 and R = NUM_NEIGHBORS in mode 1.
- wr_en and rd_en are never high together.
- wr_en and rd_en are low outside the write and read-request states.

Boundary conditions:
- Abort: en low in any state except IDLE sends the FSM to IDLE on the next edge.
  - Strobes drop that edge and no further writes are issued.
  - done stays 0.
  - Writes already issued are not undone.
- start high in IDLE, or start with en low: ignored.
- start held high across completion: ignored until the FSM reaches ARMED again via en.
- Mode 1 with NUM_NEIGHBORS = 1: single read of index 0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ARMED, WR_NODE, RD_REQ, RD_WAIT, WR_CLUS, WR_REW, DONE);
  - default base-address constants;
  - an addr() helper function.
- One natural sub-module, reward_min_tracker:
  - inputs: clear, sample strobe, value, index;
  - outputs: min value and index;
  - tie rule: keep the first (lowest-index) entry.

Test Plan:
- Mode 0, RD_LATENCY = 1, cluster = 3, node = 16'h00A5, besthop = 2, action = 1, memory Q[2] = 16'h0040.
  - Expected: writes 16'h00A5 @16'h14E, reads @16'h1CC, writes 3 @16'h4A and 16'h0040 @16'h4C.
  - done rises 5 edges after start; best_idx = 2.
- Mode 1, NUM_NEIGHBORS = 4, Q = {9, 4, 7, 4}.
  - Expected: reads 16'h1C8, 16'h1CA, 16'h1CC, 16'h1CE in order; reward = 4, best_idx = 1 (tie keeps lower index).
  - done at edge 11.
- RD_LATENCY = 3 in mode 0: rd_en is exactly 1 cycle and capture occurs 3 cycles later; done at edge 7.
- Abort: deassert en during RD_WAIT.
  - Expected: IDLE next edge, no WR_CLUS/WR_REW writes, done = 0.
  - A fresh en + start then completes normally.
- Async reset pulse mid-WR_NODE: all outputs 0 without a clock edge; after release the block sits in IDLE.
- Wrap: action = 16'h7FFF with BASE_PKT = 16'h48.
  - Expected: slot address 16'h0046, reward address 16'h0048 (modulo 2^16).
